// File: rtl/db_rx_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : db_rx_queue_pkg
//  Description : Shared constants, FSM state encoding and the response-word
//                builder for the SRIO doorbell receive queue.
//                Build macro DB_RETRY_EN: when defined, a doorbell refused
//                for a full queue is answered RETRY (4'h3) instead of
//                ERROR (4'h7).
//  Contents    : FTYPE_DOORBELL, RESP_NODATA, ST_DONE/ST_RETRY/ST_ERROR,
//                ST_FULL (status used on a full queue), db_state_t,
//                build_resp()
//  Revision    : 1.0 - initial release
// ============================================================================
package db_rx_queue_pkg;

    // HELLO header ftype/ttype byte identifying a doorbell request
    localparam logic [7:0] FTYPE_DOORBELL = 8'hA0;
    // HELLO header ftype/ttype byte for a response without data
    localparam logic [7:0] RESP_NODATA    = 8'hD0;

    localparam logic [3:0] ST_DONE  = 4'h0;
    localparam logic [3:0] ST_RETRY = 4'h3;
    localparam logic [3:0] ST_ERROR = 4'h7;

`ifdef DB_RETRY_EN
    localparam logic [3:0] ST_FULL = ST_RETRY;
`else
    localparam logic [3:0] ST_FULL = ST_ERROR;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_RESP   = 2'd2
    } db_state_t;

    // Response HELLO word. The response priority is one above the request
    // priority; the 2-bit add wraps 3 back to 0 on purpose.
    function automatic logic [63:0] build_resp(
        input logic [7:0] tid,
        input logic [1:0] prio,
        input logic [3:0] status
    );
        logic [1:0] resp_prio;
        resp_prio = prio + 2'd1;
        return {tid, RESP_NODATA, 1'b0, resp_prio, 1'b0, status, 40'd0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/db_rx_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : db_rx_queue_if
//  Description : 64-bit AXI4-Stream channel used for both the SRIO request
//                (treq) and response (tresp) ports of the doorbell queue.
//  Signals     : tvalid, tready, tdata[63:0], tkeep[7:0], tlast, tuser[31:0]
//  Modports    : master - drives payload/tvalid, receives tready
//                slave  - receives payload/tvalid, drives tready
//  Revision    : 1.0 - initial release
// ============================================================================
interface db_rx_queue_if;

    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic [31:0] tuser;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface
`default_nettype wire

// File: rtl/db_rx_queue_info_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : db_rx_queue_info_fifo
//  Description : Synchronous first-word-fall-through FIFO holding doorbell
//                info words. A push while full is honoured only when a pop
//                happens in the same cycle; a pop while empty is ignored.
//  Ports       : aclk, aresetn     clock, async active-low reset
//                push, push_data   write request / data
//                pop               remove head entry
//                rd_data, rd_valid head entry (0 when empty) / non-empty
//                full, count       full flag / entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module db_rx_queue_info_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic             aclk,
    input  wire logic             aresetn,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic      [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_count == '0);
    assign full      = (r_count == DEPTH[AW:0]);
    assign w_do_pop  = pop && !w_empty;
    // A same-cycle pop frees the slot the push needs, so full is no obstacle
    assign w_do_push = push && (!full || w_do_pop);

    // DEPTH is a power of two, so the natural pointer roll-over is modulo DEPTH
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the empty gating below hides stale contents
    always_ff @(posedge aclk) begin
        if (w_do_push) mem[r_wr_ptr] <= push_data;
    end

    assign rd_data  = w_empty ? '0 : mem[r_rd_ptr];
    assign rd_valid = !w_empty;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/db_rx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : db_rx_queue
//  Description : SRIO doorbell receive engine. Accepts HELLO doorbell
//                requests (ftype/ttype 8'hA0) on treq while the NWRITE
//                engine is idle, queues their 16-bit info for software and
//                answers each one on tresp: DONE when queued, ERROR (RETRY
//                when built with DB_RETRY_EN) when the queue is full.
//  Ports       : aclk, aresetn      clock, async active-low reset
//                nw_busy            NWRITE engine busy, blocks acceptance
//                s_axis_treq        AXIS request channel (slave)
//                m_axis_tresp       AXIS response channel (master)
//                db_rd_en           pop head info entry
//                db_rd_data/valid   head info entry / queue non-empty
//                db_count           entries held
//                db_irq             level: queue non-empty
//                db_irq_pulse       one cycle per queued doorbell
//                ovf_count, ovf_clr saturating refusal count / clear
//  Macro       : DB_RETRY_EN selects RETRY as the full-queue status
//  Revision    : 1.0 - initial release
// ============================================================================
module db_rx_queue
    import db_rx_queue_pkg::*;
#(
    parameter logic [15:0] C_SRIO_DEV_ID = 16'hF201,
    parameter int          C_DEPTH       = 16,
    parameter int          C_OVF_W       = 16
) (
    input  wire logic                      aclk,
    input  wire logic                      aresetn,
    input  wire logic                      nw_busy,
    db_rx_queue_if.slave                   s_axis_treq,
    db_rx_queue_if.master                  m_axis_tresp,
    input  wire logic                      db_rd_en,
    output logic      [15:0]               db_rd_data,
    output logic                           db_rd_valid,
    output logic      [$clog2(C_DEPTH):0]  db_count,
    output logic                           db_irq,
    output logic                           db_irq_pulse,
    output logic      [C_OVF_W-1:0]        ovf_count,
    input  wire logic                      ovf_clr
);

    db_state_t          r_state;
    db_state_t          w_state_nxt;
    logic               w_treq_ready;
    logic               w_resp_valid;
    logic               w_detect;
    logic               w_accept;
    logic               w_push_ok;
    logic               w_fifo_full;

    logic [7:0]         r_tid;
    logic [1:0]         r_prio;
    logic [15:0]        r_src_id;
    logic [3:0]         r_status;
    logic               r_irq_pulse;
    logic [C_OVF_W-1:0] r_ovf_count;

    // Header fields this engine never looks at
    logic               unused_treq;
    assign unused_treq = ^{s_axis_treq.tkeep, s_axis_treq.tlast,
                           s_axis_treq.tdata[47], s_axis_treq.tdata[44:32],
                           s_axis_treq.tdata[15:0], s_axis_treq.tuser[15:0]};

    assign w_detect = s_axis_treq.tvalid
                   && (s_axis_treq.tdata[55:48] == FTYPE_DOORBELL)
                   && !nw_busy;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // ACCEPT raises tready for exactly one cycle; the source holds tvalid,
    // so that cycle is always a completed handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_treq_ready = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_detect) w_state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                w_treq_ready = 1'b1;
                w_state_nxt  = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                if (m_axis_tresp.tready) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = (r_state == S_ACCEPT);
    // A full queue still takes the entry when software pops the head now
    assign w_push_ok = !w_fifo_full || db_rd_en;

    // ------------------------------------------------------------------
    // Request capture, response status, interrupt pulse, overflow counter
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tid       <= '0;
            r_prio      <= '0;
            r_src_id    <= '0;
            r_status    <= ST_DONE;
            r_irq_pulse <= 1'b0;
        end else begin
            r_irq_pulse <= w_accept && w_push_ok;
            if (w_accept) begin
                r_tid    <= s_axis_treq.tdata[63:56];
                r_prio   <= s_axis_treq.tdata[46:45];
                r_src_id <= s_axis_treq.tuser[31:16];
                r_status <= w_push_ok ? ST_DONE : ST_FULL;
            end
        end
    end

    // Clear has priority over a same-cycle refusal
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ovf_count <= '0;
        end else if (ovf_clr) begin
            r_ovf_count <= '0;
        end else if (w_accept && !w_push_ok && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Info FIFO
    // ------------------------------------------------------------------
    db_rx_queue_info_fifo #(
        .WIDTH (16),
        .DEPTH (C_DEPTH)
    ) u_info_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (w_accept),
        .push_data (s_axis_treq.tdata[31:16]),
        .pop       (db_rd_en),
        .rd_data   (db_rd_data),
        .rd_valid  (db_rd_valid),
        .full      (w_fifo_full),
        .count     (db_count)
    );

    // ------------------------------------------------------------------
    // Outputs; response payload is forced to zero outside RESP so every
    // output reads 0 during and straight after reset.
    // ------------------------------------------------------------------
    assign s_axis_treq.tready  = w_treq_ready;

    assign m_axis_tresp.tvalid = w_resp_valid;
    assign m_axis_tresp.tdata  = w_resp_valid ? build_resp(r_tid, r_prio, r_status) : 64'd0;
    assign m_axis_tresp.tkeep  = w_resp_valid ? 8'hFF : 8'h00;
    assign m_axis_tresp.tlast  = w_resp_valid;
    assign m_axis_tresp.tuser  = w_resp_valid ? {C_SRIO_DEV_ID, r_src_id} : 32'd0;

    assign db_irq       = db_rd_valid;
    assign db_irq_pulse = r_irq_pulse;
    assign ovf_count    = r_ovf_count;

endmodule
`default_nettype wire
